// File: rtl/sump_cmd_tx.sv
// sump_cmd_tx: SUMP host-side command serialiser.
// Accepts one opcode (+ 32-bit config word for long commands, opcode[7]=1)
// and shifts it out as UART frames: opcode first, then data LSB byte first.
// Optional build macro SUMP_CMD_TX_PARITY_EN adds an even-parity bit per frame.
module sump_cmd_tx #(
    parameter int FREQ     = 100000000,
    parameter int BAUDRATE = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [31:0] cmd_data,
    output logic        busy,
    output logic        done,
    output logic        uart_tx
);

    localparam int DIV = FREQ / BAUDRATE;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] BAUD_LOAD = CW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SUMP_CMD_TX_PARITY_EN
        PARITY,
`endif
        STOP,
        DONE
    } state_t;

    state_t         state, state_nxt;
    logic [39:0]    shreg;
    logic [CW-1:0]  baud_cnt;
    logic [2:0]     bit_idx;
    logic [2:0]     byte_cnt;   // bytes still to send, including the current one
`ifdef SUMP_CMD_TX_PARITY_EN
    logic           par;        // parity of the byte currently on the line
`endif
    logic           accept;
    logic           tick;

    assign cmd_ready = (state == IDLE) || (state == DONE);
    assign busy      = !cmd_ready;
    assign done      = (state == DONE);
    assign accept    = cmd_valid && cmd_ready;
    assign tick      = (baud_cnt == '0);

    // State register; reset aborts any frame in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and line drive
    always_comb begin
        state_nxt = state;
        uart_tx   = 1'b1;
        case (state)
            IDLE, DONE: state_nxt = accept ? START : IDLE;
            START: begin
                uart_tx = 1'b0;
                if (tick) state_nxt = DATA;
            end
            DATA: begin
                uart_tx = shreg[0];
`ifdef SUMP_CMD_TX_PARITY_EN
                if (tick && bit_idx == 3'd7) state_nxt = PARITY;
`else
                if (tick && bit_idx == 3'd7) state_nxt = STOP;
`endif
            end
`ifdef SUMP_CMD_TX_PARITY_EN
            PARITY: begin
                uart_tx = par;
                if (tick) state_nxt = STOP;
            end
`endif
            STOP: begin
                // Next byte starts with no gap after the stop bit
                if (tick) state_nxt = (byte_cnt != 3'd1) ? START : DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, baud countdown, bit/byte bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_cnt <= '0;
`ifdef SUMP_CMD_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else if (accept) begin
            shreg    <= {cmd_data, cmd_opcode};
            byte_cnt <= cmd_opcode[7] ? 3'd5 : 3'd1;
            baud_cnt <= BAUD_LOAD;
            bit_idx  <= '0;
`ifdef SUMP_CMD_TX_PARITY_EN
            par      <= ^cmd_opcode;
`endif
        end else begin
            case (state)
                START, STOP
`ifdef SUMP_CMD_TX_PARITY_EN
                , PARITY
`endif
                : begin
                    if (tick) begin
                        baud_cnt <= BAUD_LOAD;
                        bit_idx  <= '0;
                        if (state == STOP) begin
                            byte_cnt <= byte_cnt - 3'd1;
`ifdef SUMP_CMD_TX_PARITY_EN
                            // shreg already advanced by 8: low byte is the next one
                            par      <= ^shreg[7:0];
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        baud_cnt <= BAUD_LOAD;
                        shreg    <= {1'b0, shreg[39:1]};
                        bit_idx  <= bit_idx + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sump_cmd_tx.sv
// tb_sump_cmd_tx: waveform-level model of the command line plus a UART
// decoder; directed commands with hand-computed byte and timing expectations.
module tb_sump_cmd_tx;

    localparam int FREQ = 1600, BAUDRATE = 100, DIV = 16;
`ifdef SUMP_CMD_TX_PARITY_EN
    localparam int FB = 11;
    localparam int T_SHORT = 177, T_LONG = 881;
`else
    localparam int FB = 10;
    localparam int T_SHORT = 161, T_LONG = 801;
`endif

    logic        clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
    logic [7:0]  cmd_opcode = '0;
    logic [31:0] cmd_data = '0;
    logic        cmd_ready, busy, done, uart_tx;

    sump_cmd_tx #(.FREQ(FREQ), .BAUDRATE(BAUDRATE)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_data(cmd_data), .busy(busy),
        .done(done), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            if (fails < 40) $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model: expected line as a list of bits ----------
    bit       m_bits[$];
    int       m_t = -1;
    int       m_total = 0;
    int       acc_q[$];
    int       done_q[$];
    logic [3:0] exp_v;

    function automatic void build(input logic [7:0] op, input logic [31:0] d);
        logic [7:0] b[$];
        m_bits.delete();
        b.push_back(op);
        if (op[7]) for (int i = 0; i < 4; i++) b.push_back(d[8*i +: 8]);
        foreach (b[j]) begin
            m_bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) m_bits.push_back(b[j][i]);
`ifdef SUMP_CMD_TX_PARITY_EN
            m_bits.push_back(^b[j]);
`endif
            m_bits.push_back(1'b1);
        end
        m_total = m_bits.size() * DIV;
    endfunction

    // Every cycle: compare {uart_tx, busy, cmd_ready, done} with the model
    always @(negedge clk) begin
        cyc++;
        if (rst || m_t < 0)     exp_v = 4'b1010;
        else if (m_t < m_total) exp_v = {m_bits[m_t / DIV], 3'b100};
        else                    exp_v = 4'b1011;
        check("cycle", {60'd0, uart_tx, busy, cmd_ready, done}, {60'd0, exp_v});
        if (done) done_q.push_back(cyc);
        if (rst) m_t = -1;
        else begin
            if (m_t >= 0) m_t++;
            if (m_t > m_total) m_t = -1;
            if (cmd_valid && exp_v[1]) begin
                build(cmd_opcode, cmd_data);
                m_t = 0;
                acc_q.push_back(cyc);
            end
        end
    end

    // ---------------- UART decoder (mid-bit sampling) ---------------------------
    logic [7:0] rxq[$];
    logic [7:0] rx_byte;
    logic       rx_par = 1'b0;
    bit         rx_on = 0;
    int         rx_n = 0, rx_bad_stop = 0;

    always @(negedge clk) begin
        if (rst) rx_on = 0;
        else if (!rx_on) begin
            if (!uart_tx) begin rx_on = 1; rx_n = 0; end
        end else rx_n++;
        if (rx_on && (rx_n % DIV) == DIV / 2) begin
            if (rx_n / DIV >= 1 && rx_n / DIV <= 8) rx_byte[rx_n / DIV - 1] = uart_tx;
            if (FB == 11 && rx_n / DIV == 9) rx_par = uart_tx;
            if (rx_n / DIV == FB - 1) begin
                if (!uart_tx) rx_bad_stop++;
                rxq.push_back(rx_byte);
                rx_on = 0;
            end
        end
    end

    // ---------------- stimulus helpers -----------------------------------------
    task automatic wait_accept();
        int n = 0;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 2000);
        if (!cmd_ready) check("accept_timeout", cmd_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] op, input logic [31:0] d);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_data = d;
        wait_accept();
        cmd_valid = 1'b0; cmd_opcode = 8'($urandom); cmd_data = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 3000);
        if (!done) check("done_timeout", done, 1);
        #1;
    endtask

    task automatic clear_logs();
        rxq.delete(); acc_q.delete(); done_q.delete();
    endtask

    // ---------------- directed sequence ----------------------------------------
    initial begin
        int low;
        repeat (3) @(negedge clk);
        check("rst_tx", uart_tx, 1);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1 rst = 1'b0;
        low = 0;
        repeat (200) begin @(negedge clk); if (!uart_tx) low++; end
        check("idle_line", low, 0);

        // short command
        clear_logs();
        send(8'h01, 32'hFFFF_FFFF);
        wait_done();
        check("short_time", done_q[0] - acc_q[0], T_SHORT);
        check("short_nbytes", rxq.size(), 1);
        check("short_byte", rxq[0], 8'h01);

        // long command
        clear_logs();
        send(8'hC0, 32'h1234_5678);
        wait_done();
        check("long_time", done_q[0] - acc_q[0], T_LONG);
        check("long_nbytes", rxq.size(), 5);
        check("long_b0", rxq[0], 8'hC0);
        check("long_b1", rxq[1], 8'h78);
        check("long_b2", rxq[2], 8'h56);
        check("long_b3", rxq[3], 8'h34);
        check("long_b4", rxq[4], 8'h12);

        // back-to-back with cmd_valid held, then stray pulses while busy
        clear_logs();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_opcode = 8'h02; cmd_data = 32'h0;
        wait_accept();
        cmd_opcode = 8'h80; cmd_data = 32'hDEAD_BEEF;
        wait_accept();
        cmd_opcode = 8'h55; cmd_data = 32'h0;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b0; repeat (20) @(posedge clk); #1;
            cmd_valid = 1'b1; repeat (3) @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        wait_done();
        check("b2b_accepts", acc_q.size(), 2);
        check("b2b_in_done", acc_q[1], done_q[0]);
        check("b2b_time2", done_q[1] - acc_q[1], T_LONG);
        check("b2b_nbytes", rxq.size(), 6);
        check("b2b_b0", rxq[0], 8'h02);
        check("b2b_b1", rxq[1], 8'h80);
        check("b2b_b2", rxq[2], 8'hEF);
        check("b2b_b5", rxq[5], 8'hDE);

        // reset during bit 3 of byte 2 of a long command
        clear_logs();
        send(8'h81, 32'hA5A5_A5A5);
        repeat (230) @(posedge clk); #1;
        check("pre_rst_busy", busy, 1);
        rst = 1'b1; #2;
        check("midrst_tx", uart_tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_ready", cmd_ready, 1);
        @(posedge clk); #1 rst = 1'b0;
        clear_logs();
        send(8'h11, 32'h0);
        wait_done();
        check("after_rst_time", done_q[0] - acc_q[0], T_SHORT);
        check("after_rst_nbytes", rxq.size(), 1);
        check("after_rst_byte", rxq[0], 8'h11);

`ifdef SUMP_CMD_TX_PARITY_EN
        clear_logs();
        send(8'h03, 32'h0);
        wait_done();
        check("par03_bit", rx_par, 0);
        check("par03_time", done_q[0] - acc_q[0], 177);
        clear_logs();
        send(8'h07, 32'h0);
        wait_done();
        check("par07_bit", rx_par, 1);
`endif
        check("stop_bits", rx_bad_stop, 0);
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
